// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the stack-RAM arbiter.
//   arb_state_t       : arbiter FSM encoding (idle / read in flight)
//   PORT_CPU/PORT_HOST: requester indices (port 0 = stack CPU, port 1 = host loader)
//   MAX_READ_LATENCY  : upper bound on READ_LATENCY, sizes the latency counter
package ram_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_t;

  localparam int PORT_CPU         = 0;
  localparam int PORT_HOST        = 1;
  localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of both requester ports plus the RAM-side bus.
//   p0_* / p1_* : req, we, addr, wdata, (lock), ready, rvalid, rdata
//   ram_*       : address, wren, data to RAM; q from RAM
// Modports:
//   slave  : the arbiter (receives commands, drives the RAM)
//   master : the requester/RAM environment side
// Optional macro RAM_ARB_LOCK_EN adds p0_lock / p1_lock.
interface ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          p0_req, p0_we, p0_ready, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_ready, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_data, ram_q;
`ifdef RAM_ARB_LOCK_EN
  logic          p0_lock, p1_lock;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    output p1_ready, p1_rvalid, p1_rdata,
    output ram_address, ram_wren, ram_data,
    input  ram_q
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  ram_address, ram_wren, ram_data,
    output ram_q
  );
`else
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ready, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ready, p1_rvalid, p1_rdata,
    output ram_address, ram_wren, ram_data,
    input  ram_q
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ready, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ready, p1_rvalid, p1_rdata,
    input  ram_address, ram_wren, ram_data,
    output ram_q
  );
`endif
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: two-request round-robin picker, purely combinational.
//   req[1:0]   : active requests
//   prefer     : port favoured on a tie (0 = port 0, 1 = port 1)
//   enable     : gate; no grant when low
//   grant[1:0] : one-hot (or zero) grant
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prefer,
  input  logic       enable,
  output logic [1:0] grant
);
  assign grant[0] = enable & req[0] & (~req[1] | ~prefer);
  assign grant[1] = enable & req[1] & (~req[0] |  prefer);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port stack RAM between the CPU core (port 0)
// and the host/debug loader (port 1), round-robin, one read in flight.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : ram_arbiter_if.slave (both req/ready/rvalid ports + RAM bus)
// Parameters: AW, DW, READ_LATENCY (1..MAX_READ_LATENCY edges, address to q).
// Optional macro RAM_ARB_LOCK_EN: per-port lock giving exclusive ownership
// until the owner completes a command issued with lock=0.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int READ_LATENCY = 2
) (
  input logic         clock,
  input logic         reset,
  ram_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_READ_LATENCY + 1);
  localparam logic [0:0] ST_IDLE    = ARB_IDLE;
  localparam logic [0:0] ST_RD_WAIT = ARB_RD_WAIT;

  logic [0:0]              state;
  logic                    ptr;    // 0: port 0 wins ties
  logic                    owner;  // port waiting for read data
  logic [CW-1:0]           cnt;
  logic [1:0]              req, req_m, we, grant, rvalid;
  logic [1:0][AW-1:0]      addr;
  logic [1:0][DW-1:0]      wdata, rdata;
  logic [AW-1:0]           ram_address_q;
  logic [DW-1:0]           ram_data_q;
  logic                    ram_wren_q;
  logic                    acc, win, rd_done;

  assign req   = {bus.p1_req,   bus.p0_req};
  assign we    = {bus.p1_we,    bus.p0_we};
  assign addr  = {bus.p1_addr,  bus.p0_addr};
  assign wdata = {bus.p1_wdata, bus.p0_wdata};

  // Last wait cycle: q is valid now and is captured at the closing edge.
  assign rd_done = (state == ST_RD_WAIT) && (cnt == CW'(1));

`ifdef RAM_ARB_LOCK_EN
  logic [1:0] lock;
  logic       locked, lock_port, rd_unlock;

  assign lock = {bus.p1_lock, bus.p0_lock};

  // A locked-out port simply looks idle to the picker.
  always_comb begin
    req_m = req;
    if (locked) req_m[~lock_port] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      locked    <= 1'b0;
      lock_port <= 1'b0;
      rd_unlock <= 1'b0;
    end else begin
      if (acc) begin
        if (lock[win]) begin
          locked    <= 1'b1;
          lock_port <= win;
          rd_unlock <= 1'b0;
        end else if (we[win]) begin
          locked    <= 1'b0;  // unlocked write releases at acceptance
        end else begin
          rd_unlock <= 1'b1;  // unlocked read releases when data returns
        end
      end
      if (rd_done && rd_unlock) locked <= 1'b0;
    end
  end
`else
  assign req_m = req;
`endif

  rr_pick2 u_pick (
    .req    (req_m),
    .prefer (ptr),
    .enable (!reset && (state == ST_IDLE)),
    .grant  (grant)
  );

  assign acc = |grant;
  assign win = grant[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      cnt           <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      rvalid        <= '0;
      rdata         <= '0;
    end else begin
      ram_wren_q <= 1'b0;
      rvalid     <= '0;
      if (acc) begin
        ram_address_q <= addr[win];
        ram_data_q    <= wdata[win];
        ram_wren_q    <= we[win];
        ptr           <= ~win;
        if (!we[win]) begin
          state <= ST_RD_WAIT;
          owner <= win;
          cnt   <= CW'(READ_LATENCY);
        end
      end
      if (rd_done) begin
        rdata[owner]  <= bus.ram_q;
        rvalid[owner] <= 1'b1;
        state         <= ST_IDLE;
      end else if (state == ST_RD_WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign bus.p0_ready    = grant[PORT_CPU];
  assign bus.p1_ready    = grant[PORT_HOST];
  assign bus.p0_rvalid   = rvalid[PORT_CPU];
  assign bus.p1_rvalid   = rvalid[PORT_HOST];
  assign bus.p0_rdata    = rdata[PORT_CPU];
  assign bus.p1_rdata    = rdata[PORT_HOST];
  assign bus.ram_address = ram_address_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.ram_data    = ram_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW = 16, DW = 16, RL = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  ram_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(RL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM model: latency RL=2 counted from the edge that drives ram_address,
  // so q is registered once from the address bus.
  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];
  initial for (int i = 0; i < 256; i++) begin mem[i] = '0; shadow[i] = '0; end
  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_address[7:0]] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address[7:0]];
  end

  // Scoreboard: expected read returns, pushed at acceptance.
  typedef struct { bit port; logic [DW-1:0] data; int cyc; } exp_t;
  exp_t sb[$];

  always @(negedge clock) begin
    exp_t e;
    if (reset) sb.delete();
    else begin
      if (bus.p0_rvalid && bus.p1_rvalid) begin
        errors++; $display("FAIL rvalid_both: both ports rvalid at cycle %0d", cyc);
      end
      if (bus.p0_rvalid || bus.p1_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_unexpected: rvalid at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.p1_rvalid !== e.port || cyc !== e.cyc ||
              (e.port ? bus.p1_rdata : bus.p0_rdata) !== e.data) begin
            errors++;
            $display("FAIL sb_read: got port %0d cyc %0d data %h, expected port %0d cyc %0d data %h",
                     bus.p1_rvalid, cyc, e.port ? bus.p1_rdata : bus.p0_rdata, e.port, e.cyc, e.data);
          end
        end
      end
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        checks++; errors++;
        $display("FAIL sb_missing: read due cycle %0d never returned (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (bus.p0_ready) begin
        if (bus.p0_we) shadow[bus.p0_addr[7:0]] = bus.p0_wdata;
        else sb.push_back('{1'b0, shadow[bus.p0_addr[7:0]], cyc + RL + 1});
      end
      if (bus.p1_ready) begin
        if (bus.p1_we) shadow[bus.p1_addr[7:0]] = bus.p1_wdata;
        else sb.push_back('{1'b1, shadow[bus.p1_addr[7:0]], cyc + RL + 1});
      end
    end
  end

  task automatic drv(input int p, input bit rq, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit lk);
    if (p == 0) begin bus.p0_req = rq; bus.p0_we = w; bus.p0_addr = a; bus.p0_wdata = d; end
    else        begin bus.p1_req = rq; bus.p1_we = w; bus.p1_addr = a; bus.p1_wdata = d; end
`ifdef RAM_ARB_LOCK_EN
    if (p == 0) bus.p0_lock = lk; else bus.p1_lock = lk;
`else
    if (lk) $display("note: lock ignored in this build");
`endif
  endtask

  // Waits (bounded) for the given port's ready; caller compares ok.
  task automatic wait_ready(input int p, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clock);
      ok = (p == 0) ? bus.p0_ready : bus.p1_ready;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(0, 1, 1, 16'h0010, 16'hBEEF, 0);
    drv(1, 0, 0, 16'h0000, 16'h0000, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({bus.p0_ready, bus.p1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {bus.p0_ready, bus.p1_ready});
    end
    checks++;
    if ({bus.ram_address, bus.ram_data, bus.ram_wren} !== '0) begin
      errors++; $display("FAIL reset_ram: got addr %h data %h wren %b expected 0", bus.ram_address, bus.ram_data, bus.ram_wren);
    end
    checks++;
    if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata} !== '0) begin
      errors++; $display("FAIL reset_rd: got rvalid %b%b rdata %h %h expected 0", bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata);
    end
  endtask

  // Write request is already held from the reset test.
  task automatic test_write();
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.p0_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", bus.p0_ready); end
    @(posedge clock); #1 drv(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (bus.ram_address !== 16'h0010 || bus.ram_wren !== 1'b1 || bus.ram_data !== 16'hBEEF) begin
      errors++; $display("FAIL wr_bus: got addr %h wren %b data %h expected 0010 1 beef", bus.ram_address, bus.ram_wren, bus.ram_data);
    end
    @(negedge clock);
    checks++;
    if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL wr_pulse: got wren %b expected 0", bus.ram_wren); end
  endtask

  task automatic test_read();
    bit ok, got; int t;
    @(posedge clock); #1 drv(0, 1, 0, 16'h0010, 0, 0);
    wait_ready(0, 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_ready: got 0 expected 1"); end
    t = cyc;
    @(posedge clock); #1 drv(0, 0, 0, 0, 0, 0);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clock);
      if (bus.p1_rvalid) begin errors++; $display("FAIL rd_p1_rvalid: got 1 expected 0"); end
      got = bus.p0_rvalid;
    end
    checks++;
    if (!got || cyc - t !== RL + 1) begin
      errors++; $display("FAIL rd_latency: got %0d (seen %b) expected %0d", cyc - t, got, RL + 1);
    end
    checks++;
    if (bus.p0_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected beef", bus.p0_rdata); end
    @(negedge clock);
    checks++;
    if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL rd_hold: got rvalid %b data %h expected 0 beef", bus.p0_rvalid, bus.p0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] g, exp_g;
    @(posedge clock); #1 reset = 1'b1;
    drv(0, 1, 1, 16'h0020, 16'hA0A0, 0);
    drv(1, 1, 1, 16'h0030, 16'hB1B1, 0);
    @(posedge clock); #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      g = {bus.p1_ready, bus.p0_ready};
      exp_g = (i % 2) ? 2'b10 : 2'b01;
      checks++;
      if (g !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", i, g, exp_g); end
      if (i > 0) begin
        checks++;
        if (bus.ram_wren !== 1'b1 || bus.ram_address !== ((i % 2) ? 16'h0020 : 16'h0030)) begin
          errors++; $display("FAIL b2b_ram[%0d]: got wren %b addr %h", i, bus.ram_wren, bus.ram_address);
        end
      end
    end
    @(posedge clock); #1 drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_read_blocks_write();
    bit ok, done;
    @(posedge clock); #1 drv(1, 1, 0, 16'h0030, 0, 0);
    wait_ready(1, 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL blk_p1_ready: got 0 expected 1"); end
    @(posedge clock); #1 drv(1, 0, 0, 0, 0, 0); drv(0, 1, 1, 16'h0040, 16'hC0DE, 0);
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clock);
      checks++;
      if (bus.p1_rvalid) begin
        done = 1'b1;
        if (bus.p0_ready !== 1'b1) begin errors++; $display("FAIL blk_grant_at_rvalid: got %b expected 1", bus.p0_ready); end
      end else if (bus.p0_ready !== 1'b0) begin
        errors++; $display("FAIL blk_p0_ready: got %b expected 0 at cycle %0d", bus.p0_ready, cyc);
      end
    end
    if (!done) begin checks++; errors++; $display("FAIL blk_timeout: got no p1_rvalid expected one"); end
    @(posedge clock); #1 drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_read();
    bit ok, seen;
    @(posedge clock); #1 drv(1, 1, 0, 16'h0040, 0, 0);
    wait_ready(1, 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmr_ready: got 0 expected 1"); end
    @(posedge clock); #1 drv(1, 0, 0, 0, 0, 0); reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.ram_address, bus.ram_data, bus.ram_wren, bus.p0_rdata, bus.p1_rdata,
         bus.p0_rvalid, bus.p1_rvalid, bus.p0_ready, bus.p1_ready} !== '0) begin
      errors++; $display("FAIL rmr_outputs: got addr %h wren %b rdata %h %h expected all 0",
                         bus.ram_address, bus.ram_wren, bus.p0_rdata, bus.p1_rdata);
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (bus.p0_rvalid || bus.p1_rvalid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rmr_dropped: got rvalid expected none"); end
    @(posedge clock); #1 drv(1, 1, 0, 16'h0040, 0, 0);
    wait_ready(1, 5, ok);
    @(posedge clock); #1 drv(1, 0, 0, 0, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin @(negedge clock); seen = bus.p1_rvalid; end
    checks++;
    if (!ok || !seen || bus.p1_rdata !== 16'hC0DE) begin
      errors++; $display("FAIL rmr_reread: got ready %b rvalid %b data %h expected 1 1 c0de", ok, seen, bus.p1_rdata);
    end
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    bit ok, done;
    @(posedge clock); #1 drv(1, 1, 0, 16'h0030, 0, 1);
    wait_ready(1, 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lock_rd_ready: got 0 expected 1"); end
    @(posedge clock); #1 drv(1, 1, 1, 16'h0060, 16'h6666, 0); drv(0, 1, 1, 16'h0050, 16'h5555, 0);
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clock);
      done = bus.p1_ready;
      checks++;
      if (bus.p0_ready !== 1'b0) begin errors++; $display("FAIL lock_p0_blocked: got %b expected 0 at cycle %0d", bus.p0_ready, cyc); end
    end
    if (!done) begin checks++; errors++; $display("FAIL lock_timeout: got no p1 write grant expected one"); end
    @(posedge clock); #1 drv(1, 0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (bus.p0_ready !== 1'b1) begin errors++; $display("FAIL lock_release: got %b expected 1", bus.p0_ready); end
    @(posedge clock); #1 drv(0, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_read_blocks_write();
    test_reset_mid_read();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    repeat (8) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
